// File: rtl/fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_drain_ctrl
//   Read-side controller for a 16-entry, 8-bit synchronous FIFO with a
//   one-cycle registered read port. Issues read strobes, absorbs the read
//   latency, and presents bytes on a valid/ready stream through a 2-entry
//   skid buffer. An optional level threshold lets the FIFO fill to a burst
//   size before draining starts.
//
//   Optional feature: define FIFO_DRAIN_TIMEOUT_EN to add an idle counter
//   that forces a drain after TIMEOUT cycles spent collecting.
//
// Ports
//   clk            in   clock, all logic on posedge
//   rst_n          in   synchronous active-low reset
//   fifo_empty     in   FIFO empty flag
//   fifo_count     in   FIFO occupancy [CNT_W]
//   fifo_data_out  in   FIFO read data, valid the cycle after fifo_read
//   fifo_read      out  read strobe to the FIFO
//   threshold      in   burst start level [CNT_W]; 0 = drain immediately
//   flush          in   level; drain regardless of threshold while high
//   out_valid      out  output byte available
//   out_data       out  head of the skid buffer
//   out_ready      in   consumer accepts when out_valid is high
//   busy           out  FSM active, read in flight, or bytes buffered
// -----------------------------------------------------------------------------
module fifo_drain_ctrl #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 4,
  parameter int SKID_DEPTH = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_count,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_read,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [2:0] LP_DEPTH = 3'(SKID_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_inflight;
  logic [1:0]        r_skid_cnt;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [DATA_W-1:0] r_mem [0:1];

  logic              w_pop;
  logic              w_level_ok;
  logic              w_to_hit;
  logic [2:0]        w_commit;

  // ---------------------------------------------------------------------------
  // Read credit: a read is only issued if the byte it returns is guaranteed a
  // skid slot, counting bytes already buffered, the one in flight, and the
  // slot freed by a pop this cycle. This is what makes overflow impossible.
  // ---------------------------------------------------------------------------
  assign w_pop      = out_valid & out_ready;
  assign w_commit   = {1'b0, r_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_level_ok = (fifo_count >= threshold) | flush;

  assign fifo_read  = rst_n & (r_state == DRAIN) & ~fifo_empty &
                      (w_commit < LP_DEPTH);

`ifdef FIFO_DRAIN_TIMEOUT_EN
  // Idle counter: runs only while collecting, so a partial burst that never
  // reaches threshold still gets drained eventually.
  localparam int LP_TO_W = $clog2(TIMEOUT + 1);

  logic [LP_TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == COLLECT) begin
      r_to_cnt <= r_to_cnt + LP_TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_to_hit = (r_to_cnt == LP_TO_W'(TIMEOUT));
`else
  assign w_to_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_next = w_level_ok ? DRAIN : COLLECT;
        end
      end
      COLLECT: begin
        if (w_level_ok || w_to_hit) begin
          w_next = DRAIN;
        end else if (fifo_empty) begin
          w_next = IDLE;
        end
      end
      DRAIN: begin
        // A burst always runs to empty; threshold changes are ignored here.
        // The last fetched byte must have landed before leaving.
        if (fifo_empty && !r_inflight && !fifo_read) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read pipeline and 2-entry skid buffer (1-bit wrapping pointers).
  // The byte requested last cycle is captured unconditionally; the credit
  // rule guarantees a free slot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_skid_cnt <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
    end else begin
      r_inflight <= fifo_read;
      if (r_inflight) begin
        r_mem[r_wr_ptr] <= fifo_data_out;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({r_inflight, w_pop})
        2'b10:   r_skid_cnt <= r_skid_cnt + 2'd1;
        2'b01:   r_skid_cnt <= r_skid_cnt - 2'd1;
        default: r_skid_cnt <= r_skid_cnt;
      endcase
    end
  end

  assign out_valid = (r_skid_cnt != 2'd0);
  assign out_data  = r_mem[r_rd_ptr];
  assign busy      = (r_state != IDLE) | r_inflight | out_valid;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_ctrl
//   Bench for fifo_drain_ctrl with a behavioural 16x8 FIFO (registered read)
//   in front of it. Table-driven vectors for the basic drain, hand-written
//   sequences for threshold, stall, flush, reset and timeout corners, and a
//   negedge monitor that collects popped bytes and checks the read rules.
// -----------------------------------------------------------------------------
module tb_fifo_drain_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_empty;
  logic [3:0] fifo_count;
  logic [7:0] fifo_data_out;
  logic       fifo_read;
  logic [3:0] threshold;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;

  logic       wr_en;
  logic [7:0] wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_drain_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_count    (fifo_count),
    .fifo_data_out (fifo_data_out),
    .fifo_read     (fifo_read),
    .threshold     (threshold),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .busy          (busy)
  );

  // ---------------- behavioural FIFO ----------------
  logic [7:0] fmem [16];
  logic [4:0] fcnt;
  logic [3:0] frp, fwp;
  logic       fwr_ok;

  assign fifo_empty = (fcnt == 5'd0);
  assign fifo_count = fcnt[3:0];
  assign fwr_ok     = wr_en && (fcnt < 5'd16 || fifo_read);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt          <= '0;
      frp           <= '0;
      fwp           <= '0;
      fifo_data_out <= '0;
    end else begin
      if (fifo_read) begin
        fifo_data_out <= fmem[frp];
        frp           <= frp + 4'd1;
      end
      if (fwr_ok) begin
        fmem[fwp] <= wr_data;
        fwp       <= fwp + 4'd1;
      end
      fcnt <= fcnt + {4'd0, fwr_ok} - {4'd0, fifo_read};
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: collects popped bytes, checks no underflow, the 2-slot credit
  // limit, and output stability under back-pressure.
  logic [7:0] got [$];
  int         outstanding = 0;
  logic       stall_prev  = 1'b0;
  logic [7:0] stall_data  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      stall_prev  = 1'b0;
    end else begin
      if (fifo_read) begin
        chk("no_underflow", {31'd0, fifo_empty}, 32'd0);
        chk("credit_limit", {31'd0, (outstanding - int'(out_valid & out_ready)) < 2}, 32'd1);
      end
      if (stall_prev && out_valid) begin
        chk("stall_stable", {24'd0, out_data}, {24'd0, stall_data});
      end
      if (out_valid && out_ready) got.push_back(out_data);
      outstanding = outstanding + int'(fifo_read) - int'(out_valid & out_ready);
      stall_prev  = out_valid & ~out_ready;
      stall_data  = out_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    @(posedge clk);
    #1;
    wr_en     = w;
    wr_data   = d;
    out_ready = r;
  endtask

  task automatic drain_wait(input string nm, input int maxc, input logic [3:0] pat);
    logic done;
    done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step(1'b0, 8'h00, pat[i % 4]);
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({nm, "_idle"}, {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rdy;
    logic       e_rd;
    logic       e_vld;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    int   b;
    int   k, k_rd;
    logic seen;

    // wr  data   rdy  rd   vld  data   busy
    tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
    threshold = 4'd0; flush = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  {24'd0, out_data},  32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_read",  {31'd0, fifo_read}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ---- test 1: threshold 0, three bytes, table driven ----
    b = got.size();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].wr, tbl[i].wd, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("t1_read[%0d]", i),  {31'd0, fifo_read}, {31'd0, tbl[i].e_rd});
      chk($sformatf("t1_valid[%0d]", i), {31'd0, out_valid}, {31'd0, tbl[i].e_vld});
      chk($sformatf("t1_busy[%0d]", i),  {31'd0, busy},      {31'd0, tbl[i].e_busy});
      if (tbl[i].e_vld)
        chk($sformatf("t1_data[%0d]", i), {24'd0, out_data}, {24'd0, tbl[i].e_data});
    end
    chk("t1_count", got.size() - b, 3);

    // ---- test 2: threshold 4 ----
    threshold = 4'd4;
    b = got.size();
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA1 + 8'(i), 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      chk($sformatf("t2_hold_read[%0d]", i), {31'd0, fifo_read}, 32'd0);
      chk($sformatf("t2_hold_busy[%0d]", i), {31'd0, busy}, 32'd1);
    end
    step(1'b1, 8'hA4, 1'b1);
    drain_wait("t2", 50, 4'b1111);
    chk("t2_count", got.size() - b, 4);
    for (int i = 0; i < 4; i++)
      if (b + i < got.size())
        chk($sformatf("t2_byte[%0d]", i), {24'd0, got[b+i]}, {24'd0, 8'hA1 + 8'(i)});

    // ---- test 3: 16-byte burst, out_ready 1,0,0,1 ----
    threshold = 4'd0;
    b = got.size();
    for (int i = 0; i < 16; i++) step(1'b1, 8'h40 + 8'(i), (i % 4 == 0) || (i % 4 == 3));
    drain_wait("t3", 300, 4'b1001);
    chk("t3_count", got.size() - b, 16);
    for (int i = 0; i < 16; i++)
      if (b + i < got.size())
        chk($sformatf("t3_byte[%0d]", i), {24'd0, got[b+i]}, {24'd0, 8'h40 + 8'(i)});

    // ---- test 4: threshold 8, flush pulse ----
    threshold = 4'd8;
    b = got.size();
    step(1'b1, 8'hB1, 1'b1);
    step(1'b1, 8'hB2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      chk($sformatf("t4_hold_read[%0d]", i), {31'd0, fifo_read}, 32'd0);
    end
    step(1'b0, 8'h00, 1'b1); flush = 1'b1;
    step(1'b0, 8'h00, 1'b1); flush = 1'b0;
    drain_wait("t4", 50, 4'b1111);
    chk("t4_count", got.size() - b, 2);
    if (got.size() >= b + 2) begin
      chk("t4_byte0", {24'd0, got[b]},   {24'd0, 8'hB1});
      chk("t4_byte1", {24'd0, got[b+1]}, {24'd0, 8'hB2});
    end

    // ---- test 5: reset mid-burst ----
    threshold = 4'd0;
    b = got.size();
    for (int i = 0; i < 7; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t5_pending",  {28'd0, fifo_count}, 32'd5);
    chk("t5_head",     {24'd0, out_data},   {24'd0, 8'h60});
    step(1'b0, 8'h00, 1'b1); rst_n = 1'b0;
    @(negedge clk);
    chk("t5_read_in_rst", {31'd0, fifo_read}, 32'd0);
    step(1'b0, 8'h00, 1'b1); rst_n = 1'b1;
    @(negedge clk);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_busy",  {31'd0, busy},      32'd0);
    chk("t5_read",  {31'd0, fifo_read}, 32'd0);
    chk("t5_data",  {24'd0, out_data},  32'd0);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("t5_no_pops", got.size() - b, 0);

    // ---- test 6: threshold 10, one byte, timeout behaviour ----
    threshold = 4'd10;
    b = got.size();
    step(1'b1, 8'h70, 1'b1);
    k = -1; k_rd = -1; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      if (k >= 0) k++;
      else if (busy) k = 0;
      if (fifo_read && !seen) begin
        seen = 1'b1;
        k_rd = k;
      end
    end
`ifdef FIFO_DRAIN_TIMEOUT_EN
    chk("t6_timeout_latency", k_rd, 65);
`else
    chk("t6_no_read",    {31'd0, seen},       32'd0);
    chk("t6_held_busy",  {31'd0, busy},       32'd1);
    chk("t6_byte_kept",  {31'd0, fifo_empty}, 32'd0);
    step(1'b0, 8'h00, 1'b1); flush = 1'b1;
    step(1'b0, 8'h00, 1'b1); flush = 1'b0;
`endif
    drain_wait("t6", 50, 4'b1111);
    chk("t6_count", got.size() - b, 1);
    if (got.size() > b) chk("t6_byte", {24'd0, got[b]}, {24'd0, 8'h70});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
